// File: rtl/quad_step_decoder_pkg.sv
// rtl/quad_step_decoder_pkg.sv - phase, state and transition definitions for the quadrature decoder
package quad_pkg;

  // Phase values are {A,B}; the forward Gray order is 00 -> 01 -> 11 -> 10 -> 00.
  localparam logic [1:0] PH_00 = 2'b00;
  localparam logic [1:0] PH_01 = 2'b01;
  localparam logic [1:0] PH_11 = 2'b11;
  localparam logic [1:0] PH_10 = 2'b10;

  typedef enum logic {ST_INIT, ST_TRACK} state_t;

  typedef enum logic [1:0] {TR_NONE, TR_FWD, TR_REV, TR_ILLEGAL} trans_t;

  function automatic trans_t classify(input logic [1:0] prev, input logic [1:0] cur);
    logic [1:0] fwd_next;
    case (prev)
      PH_00:   fwd_next = PH_01;
      PH_01:   fwd_next = PH_11;
      PH_11:   fwd_next = PH_10;
      default: fwd_next = PH_00;
    endcase
    if (cur == prev)
      classify = TR_NONE;
    else if ((cur ^ prev) == 2'b11)
      classify = TR_ILLEGAL;
    else if (cur == fwd_next)
      classify = TR_FWD;
    else
      classify = TR_REV;
  endfunction

endpackage

// File: rtl/quad_step_decoder_glitch_filter.sv
// rtl/quad_step_decoder_glitch_filter.sv - per-channel synchronizer plus consecutive-sample glitch filter
module quad_glitch_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4
) (
  input  logic clk,
  input  logic clear,
  input  logic raw_in,
  output logic level_out,
  output logic stable
);

  localparam int CW = $clog2(FILT_LEN + 1);
  localparam logic [CW-1:0] LEN = CW'(FILT_LEN);

  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0]          diff_cnt;
  logic [CW-1:0]          stab_cnt;
  logic                   sample;

  assign sample = sync[SYNC_STAGES-1];
  assign stable = (stab_cnt == LEN);

  // diff_cnt runs toward a level change; stab_cnt measures how long the level has been confirmed.
  always_ff @(posedge clk) begin
    if (clear) begin
      sync      <= '0;
      level_out <= 1'b0;
      diff_cnt  <= '0;
      stab_cnt  <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], raw_in};
      if (sample == level_out) begin
        diff_cnt <= '0;
        if (stab_cnt != LEN)
          stab_cnt <= stab_cnt + 1'b1;
      end else begin
        stab_cnt <= '0;
        if (diff_cnt == LEN - 1'b1) begin
          level_out <= sample;
          diff_cnt  <= '0;
        end else begin
          diff_cnt <= diff_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/quad_step_decoder.sv
// rtl/quad_step_decoder.sv - quadrature A/B decoder producing step/dir strobes and a wrapping position
module quad_step_decoder
  import quad_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             quad_a,
  input  logic             quad_b,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             err_clr,
  output logic             step,
  output logic             dir,
  output logic [WIDTH-1:0] position,
  output logic             err
);

  logic       lvl_a, lvl_b;
  logic       stable_a, stable_b;
  logic [1:0] phase, prev_phase;
  state_t     state;
  trans_t     trans;

  quad_glitch_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_filt_a (
    .clk(clk), .clear(clear), .raw_in(quad_a), .level_out(lvl_a), .stable(stable_a)
  );

  quad_glitch_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_filt_b (
    .clk(clk), .clear(clear), .raw_in(quad_b), .level_out(lvl_b), .stable(stable_b)
  );

  assign phase = {lvl_a, lvl_b};
  assign trans = classify(prev_phase, phase);

  always_ff @(posedge clk) begin
    if (clear) begin
      state      <= ST_INIT;
      prev_phase <= PH_00;
      step       <= 1'b0;
      dir        <= 1'b1;
      position   <= '0;
      err        <= 1'b0;
    end else begin
      step <= 1'b0;
      if (err_clr)
        err <= 1'b0;
      case (state)
        ST_INIT: begin
          if (stable_a && stable_b) begin
            prev_phase <= phase;
            state      <= ST_TRACK;
          end
        end
        ST_TRACK: begin
          prev_phase <= phase;
          case (trans)
            TR_FWD: begin
              step     <= 1'b1;
              dir      <= 1'b1;
              position <= position + 1'b1;
            end
            TR_REV: begin
              step     <= 1'b1;
              dir      <= 1'b0;
              position <= position - 1'b1;
            end
            TR_ILLEGAL: err <= 1'b1;
            default: ;
          endcase
        end
        default: state <= ST_INIT;
      endcase
      // A load overrides any count change from the same cycle; step/dir still report it.
      if (load)
        position <= load_val;
    end
  end

endmodule

// File: tb/tb_quad_step_decoder.sv
// tb/tb_quad_step_decoder.sv - randomized and directed self-checking bench for quad_step_decoder
module tb_quad_step_decoder;

  localparam int WIDTH = 8;
  localparam int SYNC  = 2;
  localparam int FL    = 4;

  logic             clk = 1'b0;
  logic             clear = 1'b1;
  logic             quad_a = 1'b0;
  logic             quad_b = 1'b0;
  logic             load = 1'b0;
  logic [WIDTH-1:0] load_val = '0;
  logic             err_clr = 1'b0;
  logic             step, dir, err;
  logic [WIDTH-1:0] position;

  int n_vec = 0;
  int n_miss = 0;
  int n_steps = 0;
  int base;

  always #5 clk = ~clk;

  quad_step_decoder #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC), .FILT_LEN(FL)) dut (
    .clk(clk), .clear(clear), .quad_a(quad_a), .quad_b(quad_b), .load(load),
    .load_val(load_val), .err_clr(err_clr), .step(step), .dir(dir),
    .position(position), .err(err)
  );

  // Reference model: filters judged on windows of recent samples, decoding via Gray-index distance.
  bit             m_dly  [2][SYNC];
  bit             m_samp [2][FL];
  bit             m_ok   [2][FL];
  int             m_seen [2];
  bit             m_lvl  [2];
  bit             m_raw  [2];
  bit             m_track, m_step, m_dir, m_err, m_valid;
  bit [1:0]       m_prev, m_cur;
  bit [WIDTH-1:0] m_pos;
  bit             m_stable, m_all, m_s;
  int             m_d;

  function automatic int gray_idx(input bit [1:0] p);
    case (p)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  always @(posedge clk) begin
    m_valid = 1'b1;
    m_raw[0] = quad_a;
    m_raw[1] = quad_b;
    if (clear) begin
      for (int c = 0; c < 2; c++) begin
        for (int i = 0; i < SYNC; i++) m_dly[c][i] = 1'b0;
        m_seen[c] = 0;
        m_lvl[c]  = 1'b0;
      end
      m_track = 1'b0; m_prev = 2'b00; m_step = 1'b0;
      m_dir = 1'b1; m_err = 1'b0; m_pos = '0;
    end else begin
      m_stable = 1'b1;
      for (int c = 0; c < 2; c++) begin
        if (m_seen[c] < FL) m_stable = 1'b0;
        for (int i = 0; i < FL; i++) if (!m_ok[c][i]) m_stable = 1'b0;
      end
      m_cur  = {m_lvl[0], m_lvl[1]};
      m_step = 1'b0;
      if (err_clr) m_err = 1'b0;
      if (!m_track) begin
        if (m_stable) begin
          m_track = 1'b1;
          m_prev  = m_cur;
        end
      end else begin
        m_d = (gray_idx(m_cur) - gray_idx(m_prev) + 4) % 4;
        if (m_d == 1) begin m_step = 1'b1; m_dir = 1'b1; m_pos = m_pos + 1'b1; end
        else if (m_d == 3) begin m_step = 1'b1; m_dir = 1'b0; m_pos = m_pos - 1'b1; end
        else if (m_d == 2) m_err = 1'b1;
        m_prev = m_cur;
      end
      if (load) m_pos = load_val;
      for (int c = 0; c < 2; c++) begin
        m_s = m_dly[c][SYNC-1];
        for (int i = SYNC - 1; i > 0; i--) m_dly[c][i] = m_dly[c][i-1];
        m_dly[c][0] = m_raw[c];
        for (int i = FL - 1; i > 0; i--) begin
          m_samp[c][i] = m_samp[c][i-1];
          m_ok[c][i]   = m_ok[c][i-1];
        end
        m_samp[c][0] = m_s;
        m_ok[c][0]   = (m_s == m_lvl[c]);
        if (m_seen[c] < 1000) m_seen[c]++;
        m_all = (m_seen[c] >= FL);
        for (int i = 0; i < FL; i++) if (m_samp[c][i] == m_lvl[c]) m_all = 1'b0;
        if (m_all) m_lvl[c] = m_s;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      n_vec++;
      if ({step, dir, err, position} !== {m_step, m_dir, m_err, m_pos}) begin
        n_miss++;
        $display("FAIL cycle_cmp t=%0t step/dir/err/pos act=%b/%b/%b/%02h exp=%b/%b/%b/%02h",
                 $time, step, dir, err, position, m_step, m_dir, m_err, m_pos);
      end
      if (step === 1'b1) n_steps++;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic set_ph(input logic [1:0] p);
    quad_a = p[1];
    quad_b = p[0];
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  logic [1:0] seq [4];
  int gi, r, hold;

  initial begin
    seq[0] = 2'b00; seq[1] = 2'b01; seq[2] = 2'b11; seq[3] = 2'b10;

    // Reset with both channels high, then release: INIT must swallow the filter settling.
    set_ph(2'b11);
    repeat (3) tick();
    chk("rst_step", step, 0); chk("rst_dir", dir, 1);
    chk("rst_pos", position, 0); chk("rst_err", err, 0);
    clear = 1'b0; base = n_steps;
    repeat (20) tick();
    chk("init_steps", n_steps - base, 0); chk("init_err", err, 0);
    chk("init_pos", position, 0); chk("init_dir", dir, 1);

    clear = 1'b1; set_ph(2'b00);
    repeat (2) tick();
    clear = 1'b0;
    repeat (12) tick();

    // Forward run with latency pinned on the first step.
    base = n_steps;
    set_ph(2'b01);
    repeat (6) tick();
    chk("lat_pre", step, 0);
    tick();
    chk("lat_step", step, 1);
    repeat (3) tick();
    for (int i = 2; i < 5; i++) begin
      set_ph(seq[i % 4]);
      repeat (10) tick();
    end
    chk("fwd_steps", n_steps - base, 4); chk("fwd_dir", dir, 1); chk("fwd_pos", position, 4);

    // Reverse through zero.
    load = 1'b1; load_val = 8'h00; tick(); load = 1'b0;
    base = n_steps;
    for (int i = 3; i > 0; i--) begin
      set_ph(seq[i]);
      repeat (10) tick();
    end
    chk("rev_steps", n_steps - base, 3); chk("rev_dir", dir, 0); chk("rev_pos", position, 8'hFD);

    // Glitch rejection on A from phase 01.
    base = n_steps;
    quad_a = 1'b1; repeat (3) tick(); quad_a = 1'b0; repeat (12) tick();
    chk("glitch3_steps", n_steps - base, 0); chk("glitch3_pos", position, 8'hFD);
    quad_a = 1'b1; repeat (4) tick(); quad_a = 1'b0; repeat (12) tick();
    chk("glitch4_steps", n_steps - base, 2); chk("glitch4_pos", position, 8'hFD);
    chk("glitch4_dir", dir, 0);

    // Illegal jumps and err_clr priority.
    set_ph(2'b00); repeat (10) tick();
    base = n_steps;
    set_ph(2'b11); repeat (10) tick();
    chk("ill_err", err, 1); chk("ill_steps", n_steps - base, 0); chk("ill_pos", position, 8'hFC);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("errclr", err, 0);
    set_ph(2'b00); repeat (6) tick();
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("set_wins", err, 1);
    repeat (6) tick();

    // Load coincident with a forward step.
    set_ph(2'b01); repeat (6) tick();
    load = 1'b1; load_val = 8'h80; tick(); load = 1'b0;
    chk("ld_pos", position, 8'h80); chk("ld_step", step, 1); chk("ld_dir", dir, 1);
    repeat (10) tick();
    set_ph(2'b11); repeat (10) tick();
    chk("ld_next", position, 8'h81);

    // Clear mid-transition.
    set_ph(2'b10); repeat (3) tick();
    clear = 1'b1; tick();
    chk("mclr_step", step, 0); chk("mclr_dir", dir, 1);
    chk("mclr_pos", position, 0); chk("mclr_err", err, 0);
    clear = 1'b0;

    // Random walk with short holds, illegal jumps, loads, err_clr and rare clears.
    gi = 3;
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 99);
      if (r < 8) gi = (gi + 2) % 4;
      else if (r < 54) gi = (gi + 1) % 4;
      else gi = (gi + 3) % 4;
      set_ph(seq[gi]);
      hold = $urandom_range(1, 12);
      for (int h = 0; h < hold; h++) begin
        load     = ($urandom_range(0, 99) < 2);
        load_val = WIDTH'($urandom);
        err_clr  = ($urandom_range(0, 99) < 5);
        clear    = ($urandom_range(0, 999) < 5);
        tick();
      end
    end
    load = 1'b0; err_clr = 1'b0; clear = 1'b0;
    repeat (20) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
